cfg_write_arbiter: RTL and testbench

CFG_WRITE_ARBITER -- requirements
Module: cfg_write_arbiter

---
 rtl/cfg_write_arbiter_if.sv | 29 ++
 rtl/cfg_write_arbiter.sv | 120 ++++++++++++
 tb/tb_cfg_write_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_write_arbiter_if.sv
// Write-request bus for the two configuration requesters (A = SPI decoder, B = sequencer).
// Each requester has a valid/ready handshake carrying one register address and data byte.
interface cfg_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready
  );
endinterface

// File: rtl/cfg_write_arbiter.sv
// Two-requester round-robin arbiter committing writes into five config registers.
// Optional macro CFG_LOCK_EN adds a sticky lock register at address 0x05.
module cfg_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  cfg_write_arbiter_if.slave bus,
  output logic [DATA_W-1:0] en_out_uo,
  output logic [DATA_W-1:0] en_out_uio,
  output logic [DATA_W-1:0] en_pwm_uo,
  output logic [DATA_W-1:0] en_pwm_uio,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_err,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_LOCK = ADDR_W'(5);

  logic              vld_a_p0, vld_b_p0;
  logic [ADDR_W-1:0] addr_a_p0, addr_b_p0;
  logic [DATA_W-1:0] data_a_p0, data_b_p0;
  logic              last_grant_b;
  logic              grant_a, grant_b, commit;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic              addr_ok, wr_en, err;

  assign bus.a_ready = ~vld_a_p0;
  assign bus.b_ready = ~vld_b_p0;
  assign busy        = vld_a_p0 | vld_b_p0;

  // Stage p0: per-requester one-entry slots, cleared by their own grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a_p0 <= 1'b0;
      vld_b_p0 <= 1'b0;
    end else begin
      if (grant_a)                     vld_a_p0 <= 1'b0;
      else if (bus.a_valid && !vld_a_p0) vld_a_p0 <= 1'b1;
      if (grant_b)                     vld_b_p0 <= 1'b0;
      else if (bus.b_valid && !vld_b_p0) vld_b_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.a_valid && !vld_a_p0) begin
      addr_a_p0 <= bus.a_addr;
      data_a_p0 <= bus.a_data;
    end
    if (bus.b_valid && !vld_b_p0) begin
      addr_b_p0 <= bus.b_addr;
      data_b_p0 <= bus.b_data;
    end
  end

  // Reset value B makes A the winner of the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_grant_b <= 1'b1;
    else if (grant_a) last_grant_b <= 1'b0;
    else if (grant_b) last_grant_b <= 1'b1;
  end

  always_comb begin
    grant_a = vld_a_p0 & (~vld_b_p0 | last_grant_b);
    grant_b = vld_b_p0 & ~grant_a;
    commit  = grant_a | grant_b;
    c_addr  = grant_a ? addr_a_p0 : addr_b_p0;
    c_data  = grant_a ? data_a_p0 : data_b_p0;
  end

`ifdef CFG_LOCK_EN
  logic locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   locked <= 1'b0;
    else if (commit && c_addr == ADDR_LOCK && c_data[0]) locked <= 1'b1;
  end

  // Writes to 0x05 never raise an error; locked register writes do
  always_comb begin
    addr_ok = (c_addr <= ADDR_LAST);
    wr_en   = commit & addr_ok & ~locked;
    err     = commit & (addr_ok ? locked : (c_addr != ADDR_LOCK));
  end
`else
  always_comb begin
    addr_ok = (c_addr <= ADDR_LAST);
    wr_en   = commit & addr_ok;
    err     = commit & ~addr_ok;
  end
`endif

  // Stage p1: committed register file and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_uo      <= '0;
      en_out_uio     <= '0;
      en_pwm_uo      <= '0;
      en_pwm_uio     <= '0;
      pwm_duty_cycle <= '0;
      wr_err         <= 1'b0;
    end else begin
      wr_err <= err;
      if (wr_en) begin
        case (c_addr[2:0])
          3'd0:    en_out_uo      <= c_data;
          3'd1:    en_out_uio     <= c_data;
          3'd2:    en_pwm_uo      <= c_data;
          3'd3:    en_pwm_uio     <= c_data;
          3'd4:    pwm_duty_cycle <= c_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench for cfg_write_arbiter: reset, single write, contention, fairness,
// bad address, reset mid-flight and the lock register (or its absence).
module tb_cfg_write_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio, pwm_duty_cycle;
  logic wr_err, busy;
  int checks = 0;
  int errors = 0;

  cfg_write_arbiter_if bus ();

  cfg_write_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .en_out_uo      (en_out_uo),
    .en_out_uio     (en_out_uio),
    .en_pwm_uo      (en_pwm_uo),
    .en_pwm_uio     (en_pwm_uio),
    .pwm_duty_cycle (pwm_duty_cycle),
    .wr_err         (wr_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_a(input logic [6:0] addr, input logic [7:0] data);
    bus.a_valid = 1'b1; bus.a_addr = addr; bus.a_data = data;
    tick();
    bus.a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [6:0] addr, input logic [7:0] data);
    bus.b_valid = 1'b1; bus.b_addr = addr; bus.b_data = data;
    tick();
    bus.b_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio, pwm_duty_cycle} !== 40'h0) begin
      errors++; $display("FAIL reset_regs got %h want 0", {en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio, pwm_duty_cycle});
    end
    checks++;
    if ({bus.a_ready, bus.b_ready, wr_err, busy} !== 4'b1100) begin
      errors++; $display("FAIL reset_ctrl got %b want 1100", {bus.a_ready, bus.b_ready, wr_err, busy});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    send_a(7'h04, 8'h80);
    checks++;
    if ({bus.a_ready, busy, pwm_duty_cycle} !== {1'b0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL single_pending got rdy=%b busy=%b pwm=%h want rdy=0 busy=1 pwm=00", bus.a_ready, busy, pwm_duty_cycle);
    end
    tick();
    checks++;
    if (pwm_duty_cycle !== 8'h80) begin
      errors++; $display("FAIL single_commit got %h want 80", pwm_duty_cycle);
    end
    checks++;
    if ({bus.a_ready, busy, wr_err} !== 3'b100) begin
      errors++; $display("FAIL single_after got %b want 100", {bus.a_ready, busy, wr_err});
    end
  endtask

  task automatic test_contention();
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 7'h00; bus.a_data = 8'h11;
    bus.b_valid = 1'b1; bus.b_addr = 7'h00; bus.b_data = 8'h22;
    tick();
    idle_inputs();
    checks++;
    if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
      errors++; $display("FAIL cont_both_full got %b want 00", {bus.a_ready, bus.b_ready});
    end
    tick();
    checks++;
    if ({en_out_uo, bus.a_ready, bus.b_ready} !== {8'h11, 2'b10}) begin
      errors++; $display("FAIL cont_first got uo=%h rdy=%b want uo=11 rdy=10", en_out_uo, {bus.a_ready, bus.b_ready});
    end
    tick();
    checks++;
    if ({en_out_uo, bus.b_ready, busy} !== {8'h22, 2'b10}) begin
      errors++; $display("FAIL cont_second got uo=%h rdy=%b busy=%b want uo=22 rdy=1 busy=0", en_out_uo, bus.b_ready, busy);
    end
  endtask

  task automatic test_fairness();
    logic a_hs, b_hs;
    int a_cnt, b_cnt;
    logic [7:0] exp;
    do_reset();
    a_cnt = 0; b_cnt = 0;
    bus.a_valid = 1'b1; bus.a_addr = 7'h00; bus.a_data = 8'hA0;
    bus.b_valid = 1'b1; bus.b_addr = 7'h00; bus.b_data = 8'hB0;
    for (int k = 0; k < 9; k++) begin
      a_hs = bus.a_ready;
      b_hs = bus.b_ready;
      tick();
      if (a_hs) begin a_cnt++; bus.a_data = 8'(8'hA0 + a_cnt); end
      if (b_hs) begin b_cnt++; bus.b_data = 8'(8'hB0 + b_cnt); end
      if (k >= 1) begin
        exp = (k % 2 == 1) ? 8'(8'hA0 + (k - 1) / 2) : 8'(8'hB0 + k / 2 - 1);
        checks++;
        if (en_out_uo !== exp || busy !== 1'b1) begin
          errors++; $display("FAIL fair_edge%0d got uo=%h busy=%b want uo=%h busy=1", k, en_out_uo, busy, exp);
        end
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (en_out_uo !== 8'hA4) begin
      errors++; $display("FAIL fair_drain got %h want a4", en_out_uo);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL fair_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    send_a(7'h02, 8'h5A);
    tick();
    send_b(7'h7F, 8'hFF);
    checks++;
    if (wr_err !== 1'b0) begin
      errors++; $display("FAIL bad_early wr_err got %b want 0", wr_err);
    end
    tick();
    checks++;
    if (wr_err !== 1'b1) begin
      errors++; $display("FAIL bad_pulse wr_err got %b want 1", wr_err);
    end
    checks++;
    if ({en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio, pwm_duty_cycle} !== 40'h00_00_5A_00_00) begin
      errors++; $display("FAIL bad_regs got %h want 00005a0000", {en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio, pwm_duty_cycle});
    end
    tick();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++; $display("FAIL bad_end wr_err got %b want 0", wr_err);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    send_a(7'h01, 8'h55);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.a_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL mid_in_reset got %b want 10", {bus.a_ready, busy});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({en_out_uio, bus.a_ready} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL mid_discard got uio=%h rdy=%b want uio=00 rdy=1", en_out_uio, bus.a_ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send_a(7'h01, 8'h66);
    tick();
    checks++;
    if (en_out_uio !== 8'h66) begin
      errors++; $display("FAIL mid_first_hs got %h want 66", en_out_uio);
    end
  endtask

  task automatic test_lock();
    do_reset();
`ifdef CFG_LOCK_EN
    send_a(7'h05, 8'h00);
    tick();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++; $display("FAIL lock_clear_write wr_err got %b want 0", wr_err);
    end
    send_a(7'h05, 8'h01);
    tick();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++; $display("FAIL lock_set wr_err got %b want 0", wr_err);
    end
    send_a(7'h02, 8'hAA);
    tick();
    checks++;
    if ({en_pwm_uo, wr_err} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL lock_block got pwm_uo=%h err=%b want 00 1", en_pwm_uo, wr_err);
    end
`else
    send_a(7'h05, 8'h01);
    tick();
    checks++;
    if (wr_err !== 1'b1) begin
      errors++; $display("FAIL nolock_05 wr_err got %b want 1", wr_err);
    end
    send_a(7'h02, 8'hAA);
    tick();
    checks++;
    if ({en_pwm_uo, wr_err} !== {8'hAA, 1'b0}) begin
      errors++; $display("FAIL nolock_write got pwm_uo=%h err=%b want aa 0", en_pwm_uo, wr_err);
    end
`endif
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_write();
    test_contention();
    test_fairness();
    test_bad_addr();
    test_reset_midflight();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
